// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier that borrows the datapath ALU for every add/shift step.
// Optional macro ALU_MUL_ZERO_SKIP_EN: a start with a zero operand completes immediately.
module alu_mul_seq #(
    parameter int p_data_width  = 16,
    parameter int p_flags_width = 5
) (
    input  logic                        i_w_clk,
    input  logic                        i_w_rst_n,
    input  logic                        i_w_start,
    input  logic [p_data_width-1:0]     i_w_op_a,
    input  logic [p_data_width-1:0]     i_w_op_b,
    output logic                        o_w_busy,
    output logic                        o_w_done,
    output logic [2*p_data_width-1:0]   o_w_product,
    output logic [3:0]                  o_w_alu_opcode,
    output logic [p_data_width-1:0]     o_w_alu_in1,
    output logic [p_data_width-1:0]     o_w_alu_in2,
    output logic                        o_w_alu_carry,
    output logic                        o_w_alu_oe,
    input  logic [p_data_width-1:0]     i_w_alu_out,
    input  logic [p_flags_width-1:0]    i_w_alu_flags
);

    localparam int N  = p_data_width;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SHR = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t          state;
    logic [N-1:0]    mcand;
    logic [N-1:0]    acc_hi;
    logic [N-1:0]    acc_lo;
    logic            c_save;
    logic [CW-1:0]   cnt;

    logic [N-1:0]    shift_hi;
    logic [N-1:0]    shift_lo;
    logic            zero_skip;
    logic            unused_flags;

    // Only the carry flag matters here; the other flag bits are deliberately ignored.
    assign unused_flags  = ^i_w_alu_flags;
    assign o_w_alu_carry = 1'b0;

    // The ADD carry-out re-enters at the top of acc_hi; the bit shifted out of acc_hi feeds acc_lo.
    assign shift_hi = i_w_alu_out | {c_save, {(N-1){1'b0}}};
    assign shift_lo = {i_w_alu_flags[0], acc_lo[N-1:1]};

`ifdef ALU_MUL_ZERO_SKIP_EN
    assign zero_skip = (i_w_op_a == '0) || (i_w_op_b == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // ALU pins are registered, so each transition preloads the operands for the state being entered.
    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            state          <= S_IDLE;
            mcand          <= '0;
            acc_hi         <= '0;
            acc_lo         <= '0;
            c_save         <= 1'b0;
            cnt            <= '0;
            o_w_busy       <= 1'b0;
            o_w_done       <= 1'b0;
            o_w_product    <= '0;
            o_w_alu_opcode <= OP_ADC;
            o_w_alu_in1    <= '0;
            o_w_alu_in2    <= '0;
            o_w_alu_oe     <= 1'b0;
        end else begin
            case (state)
                S_ADD: begin
                    acc_hi         <= i_w_alu_out;
                    c_save         <= i_w_alu_flags[0];
                    state          <= S_SHIFT;
                    o_w_alu_opcode <= OP_SHR;
                    o_w_alu_in1    <= i_w_alu_out;
                    o_w_alu_in2    <= '0;
                    o_w_alu_oe     <= 1'b1;
                end

                S_SHIFT: begin
                    acc_hi <= shift_hi;
                    acc_lo <= shift_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        o_w_product    <= {shift_hi, shift_lo};
                        state          <= S_DONE;
                        o_w_busy       <= 1'b0;
                        o_w_done       <= 1'b1;
                        o_w_alu_opcode <= OP_ADC;
                        o_w_alu_in1    <= '0;
                        o_w_alu_in2    <= '0;
                        o_w_alu_oe     <= 1'b0;
                    end else begin
                        state          <= S_ADD;
                        o_w_alu_opcode <= OP_ADC;
                        o_w_alu_in1    <= shift_hi;
                        o_w_alu_in2    <= shift_lo[0] ? mcand : '0;
                        o_w_alu_oe     <= 1'b1;
                    end
                end

                default: begin
                    // IDLE and DONE share the same start handling, which gives back-to-back operation.
                    state          <= S_IDLE;
                    o_w_busy       <= 1'b0;
                    o_w_done       <= 1'b0;
                    o_w_alu_opcode <= OP_ADC;
                    o_w_alu_in1    <= '0;
                    o_w_alu_in2    <= '0;
                    o_w_alu_oe     <= 1'b0;
                    if (i_w_start) begin
                        mcand  <= i_w_op_a;
                        acc_lo <= i_w_op_b;
                        acc_hi <= '0;
                        c_save <= 1'b0;
                        cnt    <= '0;
                        if (zero_skip) begin
                            o_w_product <= '0;
                            o_w_done    <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            state       <= S_ADD;
                            o_w_busy    <= 1'b1;
                            o_w_alu_oe  <= 1'b1;
                            o_w_alu_in2 <= i_w_op_b[0] ? i_w_op_a : '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: behavioural ALU beside the DUT, products checked against a*b.
module tb_alu_mul_seq;

    localparam int N         = 16;
    localparam int FW        = 5;
    localparam int DONE_FULL = 2 * N + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [N-1:0]      op_a = '0;
    logic [N-1:0]      op_b = '0;
    logic              busy;
    logic              done;
    logic [2*N-1:0]    product;
    logic [3:0]        alu_opcode;
    logic [N-1:0]      alu_in1;
    logic [N-1:0]      alu_in2;
    logic              alu_carry;
    logic              alu_oe;
    logic [N-1:0]      alu_out;
    logic [FW-1:0]     alu_flags;

    int                vectors = 0;
    int                errors = 0;
    logic [2*N-1:0]    last_product = '0;

    always #5 clk = ~clk;

    alu_mul_seq #(.p_data_width(N), .p_flags_width(FW)) dut (
        .i_w_clk        (clk),
        .i_w_rst_n      (rst_n),
        .i_w_start      (start),
        .i_w_op_a       (op_a),
        .i_w_op_b       (op_b),
        .o_w_busy       (busy),
        .o_w_done       (done),
        .o_w_product    (product),
        .o_w_alu_opcode (alu_opcode),
        .o_w_alu_in1    (alu_in1),
        .o_w_alu_in2    (alu_in2),
        .o_w_alu_carry  (alu_carry),
        .o_w_alu_oe     (alu_oe),
        .i_w_alu_out    (alu_out),
        .i_w_alu_flags  (alu_flags)
    );

    // Behavioural datapath ALU: ADC = add with carry-out in flags[0], SHR = logical right shift with the lost bit in flags[0].
    logic [N:0] alu_sum;
    always_comb begin
        alu_sum   = '0;
        alu_out   = '0;
        alu_flags = '0;
        if (alu_opcode == 4'd0) begin
            alu_sum      = {1'b0, alu_in1} + {1'b0, alu_in2} + {{N{1'b0}}, alu_carry};
            alu_out      = alu_sum[N-1:0];
            alu_flags[0] = alu_sum[N];
        end else if (alu_opcode == 4'd8) begin
            alu_out      = alu_in1 >> 1;
            alu_flags[0] = alu_in1[0];
        end
    end

    function automatic int done_cycle(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef ALU_MUL_ZERO_SKIP_EN
        if (a == '0 || b == '0) return 1;
`endif
        return DONE_FULL;
    endfunction

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        return {{N{1'b0}}, a} * {{N{1'b0}}, b};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, alu_oe, alu_carry} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl busy/done/oe/carry got %b want 0000", {busy, done, alu_oe, alu_carry});
        end
        vectors++;
        if ({product, alu_opcode, alu_in1, alu_in2} !== '0) begin
            errors++;
            $display("FAIL reset_data product=%h opcode=%h in1=%h in2=%h want all 0", product, alu_opcode, alu_in1, alu_in2);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: checked idle outputs");
    endtask

    task automatic test_mul(input logic [N-1:0] a, input logic [N-1:0] b, input string name);
        int dc;
        logic [2*N-1:0] exp_p;
        logic [2*N-1:0] exp_prod;
        logic exp_busy;
        logic exp_done;
        dc    = done_cycle(a, b);
        exp_p = ref_mul(a, b);
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        start = 1'b0; op_a = N'($urandom); op_b = N'($urandom);
        for (int c = 1; c <= dc + 2; c++) begin
            @(negedge clk);
            exp_busy = (c < dc);
            exp_done = (c == dc);
            exp_prod = (c >= dc) ? exp_p : last_product;
            vectors++;
            if ({busy, done, alu_oe} !== {exp_busy, exp_done, exp_busy}) begin
                errors++;
                $display("FAIL %s c%0d busy/done/oe got %b want %b", name, c, {busy, done, alu_oe}, {exp_busy, exp_done, exp_busy});
            end
            vectors++;
            if (product !== exp_prod) begin
                errors++;
                $display("FAIL %s c%0d product got %h want %h", name, c, product, exp_prod);
            end
            vectors++;
            if (exp_busy) begin
                if ({alu_opcode, alu_carry} !== {(c % 2 == 1) ? 4'd0 : 4'd8, 1'b0}) begin
                    errors++;
                    $display("FAIL %s c%0d alu_op got %h/%b want %h/0", name, c, alu_opcode, alu_carry, (c % 2 == 1) ? 4'd0 : 4'd8);
                end
            end else if ({alu_opcode, alu_in1, alu_in2, alu_carry} !== '0) begin
                errors++;
                $display("FAIL %s c%0d idle_pins opcode=%h in1=%h in2=%h want 0", name, c, alu_opcode, alu_in1, alu_in2);
            end
        end
        last_product = exp_p;
        $display("%s: a=%h b=%h product=%h done_cycle=%0d", name, a, b, product, dc);
    endtask

    task automatic test_busy_start();
        logic exp_busy;
        logic exp_done;
        @(negedge clk);
        start = 1'b1; op_a = 16'd7; op_b = 16'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= DONE_FULL + 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp_busy = (c < DONE_FULL);
            exp_done = (c == DONE_FULL);
            vectors++;
            if ({busy, done} !== {exp_busy, exp_done}) begin
                errors++;
                $display("FAIL busy_start c%0d busy/done got %b want %b", c, {busy, done}, {exp_busy, exp_done});
            end
            if (c == 10) begin
                start = 1'b1; op_a = 16'd2; op_b = 16'd2;
            end
        end
        vectors++;
        if (product !== 32'd63) begin
            errors++;
            $display("FAIL busy_start product got %h want %h", product, 32'd63);
        end
        last_product = 32'd63;
        $display("busy_start: 7*9 with restart at cycle 10, product=%h", product);
    endtask

    task automatic test_back_to_back();
        logic exp_busy;
        logic exp_done;
        logic [2*N-1:0] exp_prod;
        @(negedge clk);
        start = 1'b1; op_a = 16'h1234; op_b = 16'h0010;
        for (int c = 1; c <= 2 * DONE_FULL + 4; c++) begin
            @(negedge clk);
            if (c == DONE_FULL + 1) start = 1'b0;
            exp_done = (c == DONE_FULL) || (c == 2 * DONE_FULL);
            exp_busy = (c < DONE_FULL) || (c > DONE_FULL && c < 2 * DONE_FULL);
            exp_prod = (c < DONE_FULL) ? last_product : 32'h0001_2340;
            vectors++;
            if ({busy, done, alu_oe} !== {exp_busy, exp_done, exp_busy}) begin
                errors++;
                $display("FAIL b2b c%0d busy/done/oe got %b want %b", c, {busy, done, alu_oe}, {exp_busy, exp_done, exp_busy});
            end
            vectors++;
            if (product !== exp_prod) begin
                errors++;
                $display("FAIL b2b c%0d product got %h want %h", c, product, exp_prod);
            end
        end
        last_product = 32'h0001_2340;
        $display("back_to_back: two operations, done cycles %0d and %0d", DONE_FULL, 2 * DONE_FULL);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; op_a = N'($urandom) | 16'h0001; op_b = N'($urandom) | 16'h0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 15; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, alu_oe, alu_carry, alu_opcode, alu_in1, alu_in2, product} !== '0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b oe=%b opcode=%h in1=%h in2=%h product=%h want all 0",
                     busy, done, alu_oe, alu_opcode, alu_in1, alu_in2, product);
        end
        last_product = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            vectors++;
            if ({busy, done} !== 2'b00) begin
                errors++;
                $display("FAIL reset_mid_quiet c%0d busy/done got %b want 00", c, {busy, done});
            end
        end
        $display("reset_mid: operation abandoned at cycle 15");
        test_mul(16'd2, 16'd3, "post_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        test_reset();
        test_mul(16'd3, 16'd5, "basic");
        test_mul(16'hFFFF, 16'hFFFF, "carry_ff");
        test_mul(16'h8000, 16'h0002, "carry_msb");
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        test_mul(16'h0000, 16'h1234, "zero_a");
        test_mul(16'h1234, 16'h0000, "zero_b");
        for (int i = 0; i < 10; i++) begin
            ra = N'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            test_mul(ra, rb, "random");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
